time_set_loader: RTL and testbench

- Write-side counterpart of the running clock's BCD display path: accepts a six-digit BCD time entry (HH:MM:SS), one digit per handshake.
- Validates each digit against 24-hour limits, converts the digit pairs to binary, and issues a single-cycle load to the seconds/minutes/hours counters.
- Sits between the user-input front end (debounced keypad/buttons) and the counter chain; load values use the same binary widths as the counters.

---
 rtl/time_set_loader.sv | 175 +++++++++++++++++
 tb/tb_time_set_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_loader.sv
`default_nettype none
// ============================================================================
// Module   : time_set_loader
// Brief    : Collects a six-digit BCD HH:MM:SS entry one digit per handshake,
//            validates each digit against 24-hour limits, converts the digit
//            pairs to binary and issues a single-cycle load to the counters.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned TO_WIDTH       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  output logic       digit_ready,
  output logic [2:0] digit_index,
  output logic       busy,
  output logic       digit_error,
  output logic       timeout,
  output logic       load,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_LOAD    = 2'd2
  } state_t;

  // A zero TIMEOUT_CYCLES wraps c_to_last, but c_to_en keeps it unused then.
  localparam logic                c_to_en   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] c_to_last = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [5:0][3:0]      r_digit;
  logic [2:0]           r_index;
  logic [TO_WIDTH-1:0]  r_to_cnt;
  logic                 r_digit_error;
  logic                 r_timeout;
  logic [4:0]           r_set_hours;
  logic [5:0]           r_set_minutes;
  logic [5:0]           r_set_seconds;
  logic                 w_digit_ok;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_to_hit;
  logic                 w_cnt_inc;
  logic [6:0]           w_hours_bin;
  logic [6:0]           w_minutes_bin;
  logic [6:0]           w_seconds_bin;

  // tens*10 + ones built from shifts; 7 bits covers the largest pair (99).
  function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

  // Per-slot 24-hour limit check; slot 1 depends on the stored hours tens digit.
  always_comb begin
    w_digit_ok = 1'b0;
    case (r_index)
      3'd0:       w_digit_ok = (digit_in <= 4'd2);
      3'd1:       w_digit_ok = (digit_in <= 4'd9) &&
                               ((r_digit[0] != 4'd2) || (digit_in <= 4'd3));
      3'd2, 3'd4: w_digit_ok = (digit_in <= 4'd5);
      3'd3, 3'd5: w_digit_ok = (digit_in <= 4'd9);
      default:    w_digit_ok = 1'b0;
    endcase
  end

  // The seconds-ones digit is taken straight from the input so that set_* is
  // already registered in the LOAD cycle.
  assign w_hours_bin   = bcd_pair(r_digit[0], r_digit[1]);
  assign w_minutes_bin = bcd_pair(r_digit[2], r_digit[3]);
  assign w_seconds_bin = bcd_pair(r_digit[4], digit_in);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake strobes; cancel outranks a same-cycle digit.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_to_hit    = 1'b0;
    w_cnt_inc   = 1'b0;
    load        = 1'b0;
    busy        = 1'b0;
    digit_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_COLLECT;
      end
      S_COLLECT: begin
        busy        = 1'b1;
        digit_ready = !cancel;
        if (cancel) begin
          w_next = S_IDLE;
        end else if (digit_valid) begin
          if (w_digit_ok) begin
            w_accept = 1'b1;
            if (r_index == 3'd5) w_next = S_LOAD;
          end else begin
            w_reject = 1'b1;
          end
        end else if (c_to_en && (r_to_cnt == c_to_last)) begin
          w_to_hit = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_LOAD: begin
        load   = 1'b1;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Digit storage, index/timeout bookkeeping, status pulses and load values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit       <= '0;
      r_index       <= 3'd0;
      r_to_cnt      <= '0;
      r_digit_error <= 1'b0;
      r_timeout     <= 1'b0;
      r_set_hours   <= 5'd0;
      r_set_minutes <= 6'd0;
      r_set_seconds <= 6'd0;
    end else begin
      r_digit_error <= w_reject;
      r_timeout     <= w_to_hit;
      for (int i = 0; i < 6; i++) begin
        if (w_accept && (r_index == 3'(i))) r_digit[i] <= digit_in;
      end
      if (w_next != S_COLLECT) begin
        r_index  <= 3'd0;
        r_to_cnt <= '0;
      end else if (w_accept) begin
        r_index  <= r_index + 3'd1;
        r_to_cnt <= '0;
      end else if (w_reject) begin
        r_to_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
      end
      if (w_accept && (r_index == 3'd5)) begin
        r_set_hours   <= w_hours_bin[4:0];
        r_set_minutes <= w_minutes_bin[5:0];
        r_set_seconds <= w_seconds_bin[5:0];
      end
    end
  end

  assign digit_index = r_index;
  assign digit_error = r_digit_error;
  assign timeout     = r_timeout;
  assign set_hours   = r_set_hours;
  assign set_minutes = r_set_minutes;
  assign set_seconds = r_set_seconds;

endmodule
`default_nettype wire

// File: tb/tb_time_set_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_loader
// Brief    : Scoreboard bench for time_set_loader: stimulus pushes expected
//            pulses (load / digit_error / timeout), a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_loader;

  localparam int EV_LOAD = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_TMO  = 2;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_ready;
  logic [2:0] digit_index;
  logic       busy;
  logic       digit_error;
  logic       timeout;
  logic       load;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  // Reference model: digits entered so far and the last loaded time.
  int m_idx = 0;
  int m_dig[6];
  int last_h = 0, last_m = 0, last_s = 0;
  bit m_done = 0;

  time_set_loader #(.TIMEOUT_CYCLES(16), .TO_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel),
    .digit_valid(digit_valid), .digit_in(digit_in),
    .digit_ready(digit_ready), .digit_index(digit_index), .busy(busy),
    .digit_error(digit_error), .timeout(timeout), .load(load),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A digit is legal if the partial entry can still form a valid 24-hour time.
  function automatic bit slot_ok(input int slot, input int d, input int tens0);
    case (slot)
      0:       return d <= 2;
      1:       return (tens0 * 10 + d) <= 23;
      2, 4:    return d <= 5;
      default: return d <= 9;
    endcase
  endfunction

  // Monitor: every output pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (load || digit_error || timeout) begin
      int   kind;
      exp_t e;
      kind = load ? EV_LOAD : (digit_error ? EV_ERR : EV_TMO);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got kind %0d, expected none (t=%0t)", kind, $time);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", kind, e.kind);
        if (kind == EV_LOAD && e.kind == EV_LOAD) begin
          chk("set_hours", set_hours, e.a);
          chk("set_minutes", set_minutes, e.b);
          chk("set_seconds", set_seconds, e.c);
          chk("busy_in_load", busy, 1);
        end
        if (kind == EV_ERR && e.kind == EV_ERR) chk("err_index", digit_index, e.a);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    m_idx = 0;
    m_done = 0;
    chk("busy_after_start", busy, 1);
    chk("index_after_start", digit_index, 0);
  endtask

  task automatic send(input int d);
    exp_t e;
    chk("digit_index", digit_index, m_idx);
    chk("digit_ready", digit_ready, 1);
    if (slot_ok(m_idx, d, m_dig[0])) begin
      m_dig[m_idx] = d;
      if (m_idx == 5) begin
        last_h = m_dig[0] * 10 + m_dig[1];
        last_m = m_dig[2] * 10 + m_dig[3];
        last_s = m_dig[4] * 10 + m_dig[5];
        e = '{EV_LOAD, last_h, last_m, last_s};
        q.push_back(e);
        m_idx = 0;
        m_done = 1;
      end else begin
        m_idx++;
      end
    end else begin
      e = '{EV_ERR, m_idx, 0, 0};
      q.push_back(e);
    end
    digit_valid = 1'b1;
    digit_in = 4'(d);
    cycles(1);
    digit_valid = 1'b0;
  endtask

  task automatic do_cancel(input bit with_digit, input int d);
    cancel = 1'b1;
    digit_valid = with_digit;
    digit_in = 4'(d);
    #1;
    chk("ready_under_cancel", digit_ready, 0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    digit_valid = 1'b0;
    m_idx = 0;
    chk("busy_after_cancel", busy, 0);
  endtask

  task automatic chk_held();
    chk("held_hours", set_hours, last_h);
    chk("held_minutes", set_minutes, last_m);
    chk("held_seconds", set_seconds, last_s);
  endtask

  task automatic entry(input int d0, d1, d2, d3, d4, d5);
    do_start();
    send(d0); send(d1); send(d2); send(d3); send(d4); send(d5);
  endtask

  initial begin
    exp_t e;
    int   tries;
    // Reset state
    cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_index", digit_index, 0);
    chk("rst_ready", digit_ready, 0);
    chk("rst_load", load, 0);
    chk("rst_hours", set_hours, 0);
    reset = 1'b1;
    cycles(2);

    // Basic entry 13:45:09, load latency and busy drop
    entry(1, 3, 4, 5, 0, 9);
    chk("load_latency", load, 1);
    cycles(1);
    chk("load_single", load, 0);
    chk("busy_dropped", busy, 0);
    cycles(2);

    // 2,4 rejected at slot 1, then 23:59:59
    do_start();
    send(2); send(4); send(3); send(5); send(9); send(5); send(9);
    cycles(2);
    chk_held();

    // Rejects at slot 2 and slot 0, then all zeros
    do_start();
    send(0); send(0); send(6);
    do_cancel(0, 0);
    do_start();
    send(3);
    send(0); send(0); send(0); send(0); send(0); send(0);
    cycles(2);
    chk_held();

    // Timeout after 16 idle cycles
    entry(1, 2, 3, 4, 5, 6);
    cycles(2);
    do_start();
    send(1); send(7);
    e = '{EV_TMO, 0, 0, 0};
    q.push_back(e);
    m_idx = 0;
    cycles(15);
    chk("busy_before_timeout", busy, 1);
    cycles(1);
    chk("timeout_pulse", timeout, 1);
    chk("busy_after_timeout", busy, 0);
    cycles(4);
    chk_held();

    // Cancel together with a valid digit at slot 3
    do_start();
    send(1); send(2); send(3);
    do_cancel(1, 4);
    cycles(2);
    chk_held();
    do_start();
    do_cancel(0, 0);

    // Asynchronous reset mid-entry
    do_start();
    send(2); send(1); send(3);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_index", digit_index, 0);
    chk("arst_hours", set_hours, 0);
    chk("arst_minutes", set_minutes, 0);
    chk("arst_seconds", set_seconds, 0);
    last_h = 0; last_m = 0; last_s = 0; m_idx = 0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    entry(2, 0, 3, 8, 5, 7);
    cycles(2);

    // Randomized entries with idle gaps shorter than the timeout
    for (int n = 0; n < 30; n++) begin
      do_start();
      tries = 0;
      while (!m_done && tries < 40) begin
        send(int'($urandom_range(0, 9)));
        if (!m_done) cycles(int'($urandom_range(0, 2)));
        tries++;
      end
      if (!m_done) do_cancel(0, 0);
      cycles(2);
      chk_held();
    end

    cycles(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
